// File: rtl/fft_frame_sequencer.sv
// Frame controller for the FFT core: flush, load one frame of ADC samples,
// wait for the transform, then stream magnitudes out and track the peak bin.
module fft_frame_sequencer #(
    parameter int FFT_LENGTH   = 1024,
    parameter int IDX_W        = 10,
    parameter int ADC_W        = 12,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [ADC_W-1:0] adc_data_i,
    input  logic             adc_valid_i,
    output logic             fft_reset_o,
    output logic             fft_in_valid_o,
    output logic [15:0]      fft_in_real_o,
    input  logic             fft_done_i,
    output logic [IDX_W-1:0] fft_index_o,
    input  logic [15:0]      fft_magnitude_i,
    input  logic             fft_magnitude_ready_i,
    output logic [15:0]      mag_o,
    output logic [IDX_W-1:0] mag_bin_o,
    output logic             mag_valid_o,
    output logic [15:0]      peak_mag_o,
    output logic [IDX_W-1:0] peak_bin_o,
    output logic             frame_done_o,
    output logic             sample_drop_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_LOAD, S_COMPUTE, S_READ, S_DONE
    } state_t;

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FW-1:0]    FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FFT_LENGTH - 1);
    localparam logic [IDX_W-1:0] HALF_LAST  = IDX_W'(FFT_LENGTH / 2 - 1);

    state_t           state_q;
    logic [FW-1:0]    flush_cnt_q;
    logic [IDX_W-1:0] samp_cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [15:0]      run_mag_q;
    logic [IDX_W-1:0] run_bin_q;
    logic             fft_rst_q;
    logic             in_valid_q;
    logic [15:0]      in_real_q;
    logic [15:0]      mag_q;
    logic [IDX_W-1:0] mag_bin_q;
    logic             mag_valid_q;
    logic [15:0]      peak_mag_q;
    logic [IDX_W-1:0] peak_bin_q;
    logic             frame_done_q;
    logic             drop_q;
    logic             busy_q;
    logic             is_cand;

    // Only the non-DC lower half of the spectrum can hold the peak.
    assign is_cand = (idx_q != '0) && (idx_q <= HALF_LAST)
                     && (fft_magnitude_i > run_mag_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            flush_cnt_q  <= '0;
            samp_cnt_q   <= '0;
            idx_q        <= '0;
            run_mag_q    <= '0;
            run_bin_q    <= '0;
            fft_rst_q    <= 1'b1;
            in_valid_q   <= 1'b0;
            in_real_q    <= '0;
            mag_q        <= '0;
            mag_bin_q    <= '0;
            mag_valid_q  <= 1'b0;
            peak_mag_q   <= '0;
            peak_bin_q   <= '0;
            frame_done_q <= 1'b0;
            drop_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            in_valid_q   <= 1'b0;
            mag_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= adc_valid_i && (state_q != S_LOAD);
            if (state_q != S_FLUSH) flush_cnt_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_FLUSH;
                        busy_q  <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    samp_cnt_q <= '0;
                    idx_q      <= '0;
                    if (!start_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (flush_cnt_q == FLUSH_LAST) begin
                        state_q   <= S_LOAD;
                        fft_rst_q <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!start_i) begin
                        state_q   <= S_IDLE;
                        fft_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else if (adc_valid_i) begin
                        in_valid_q <= 1'b1;
                        in_real_q  <= 16'({adc_data_i, 4'b0000});
                        samp_cnt_q <= samp_cnt_q + 1'b1;
                        if (samp_cnt_q == LAST_IDX) state_q <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (!start_i) begin
                        state_q   <= S_IDLE;
                        fft_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else if (fft_done_i) begin
                        state_q   <= S_READ;
                        run_mag_q <= '0;
                        run_bin_q <= '0;
                    end
                end
                S_READ: begin
                    if (!start_i) begin
                        state_q   <= S_IDLE;
                        fft_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else if (fft_magnitude_ready_i) begin
                        mag_q       <= fft_magnitude_i;
                        mag_bin_q   <= idx_q;
                        mag_valid_q <= 1'b1;
                        idx_q       <= idx_q + 1'b1;
                        if (is_cand) begin
                            run_mag_q <= fft_magnitude_i;
                            run_bin_q <= idx_q;
                        end
                        // Last bin is never a candidate, so the running peak is final here.
                        if (idx_q == LAST_IDX) begin
                            state_q      <= S_DONE;
                            frame_done_q <= 1'b1;
                            peak_mag_q   <= run_mag_q;
                            peak_bin_q   <= run_bin_q;
                        end
                    end
                end
                S_DONE: begin
                    fft_rst_q <= 1'b1;
                    busy_q    <= start_i;
                    state_q   <= start_i ? S_FLUSH : S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    fft_rst_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign fft_reset_o    = fft_rst_q;
    assign fft_in_valid_o = in_valid_q;
    assign fft_in_real_o  = in_real_q;
    assign fft_index_o    = idx_q;
    assign mag_o          = mag_q;
    assign mag_bin_o      = mag_bin_q;
    assign mag_valid_o    = mag_valid_q;
    assign peak_mag_o     = peak_mag_q;
    assign peak_bin_o     = peak_bin_q;
    assign frame_done_o   = frame_done_q;
    assign sample_drop_o  = drop_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: scoreboarded sample and magnitude
// streams, peak selection, abort and back-to-back frame behaviour.
module tb_fft_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [11:0] adc_data_i;
    logic        adc_valid_i;
    logic        fft_reset_o;
    logic        fft_in_valid_o;
    logic [15:0] fft_in_real_o;
    logic        fft_done_i;
    logic [9:0]  fft_index_o;
    logic [15:0] fft_magnitude_i;
    logic        fft_magnitude_ready_i;
    logic [15:0] mag_o;
    logic [9:0]  mag_bin_o;
    logic        mag_valid_o;
    logic [15:0] peak_mag_o;
    logic [9:0]  peak_bin_o;
    logic        frame_done_o;
    logic        sample_drop_o;
    logic        busy_o;

    fft_frame_sequencer dut (
        .clk                   (clk),
        .reset                 (reset),
        .start_i               (start_i),
        .adc_data_i            (adc_data_i),
        .adc_valid_i           (adc_valid_i),
        .fft_reset_o           (fft_reset_o),
        .fft_in_valid_o        (fft_in_valid_o),
        .fft_in_real_o         (fft_in_real_o),
        .fft_done_i            (fft_done_i),
        .fft_index_o           (fft_index_o),
        .fft_magnitude_i       (fft_magnitude_i),
        .fft_magnitude_ready_i (fft_magnitude_ready_i),
        .mag_o                 (mag_o),
        .mag_bin_o             (mag_bin_o),
        .mag_valid_o           (mag_valid_o),
        .peak_mag_o            (peak_mag_o),
        .peak_bin_o            (peak_bin_o),
        .frame_done_o          (frame_done_o),
        .sample_drop_o         (sample_drop_o),
        .busy_o                (busy_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;
    int n_in    = 0;
    int n_mag   = 0;
    int n_done  = 0;
    logic [15:0] in_q[$];
    logic [25:0] mag_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mag_fn(input int sel, input int k);
        if (sel == 1) begin
            if (k == 37 || k == 600) return 16'hFFFF;
            return 16'(k * 2);
        end
        if (k == 0) return 16'hFFFF;
        if (k == 5 || k == 9) return 16'd100;
        if (k == 700) return 16'hFFFE;
        return 16'(k & 63);
    endfunction

    task automatic read_frame(input int sel);
        for (int k = 0; k < 1024; k++) begin
            if (k % 3 == 2) begin
                fft_magnitude_ready_i = 1'b0;
                tick();
            end
            fft_magnitude_i       = mag_fn(sel, k);
            fft_magnitude_ready_i = 1'b1;
            mag_q.push_back({10'(k), fft_magnitude_i});
            tick();
        end
        fft_magnitude_ready_i = 1'b0;
    endtask

    // Scoreboard: pop expectations whenever the DUT presents output.
    always @(negedge clk) begin
        if (!reset) begin
            if (fft_in_valid_o) begin
                n_in++;
                chk("in_q_nonempty", 32'(in_q.size() != 0), 32'd1);
                if (in_q.size() != 0)
                    chk("in_real", 32'(fft_in_real_o), 32'(in_q.pop_front()));
            end
            if (mag_valid_o) begin
                n_mag++;
                chk("mag_q_nonempty", 32'(mag_q.size() != 0), 32'd1);
                if (mag_q.size() != 0)
                    chk("mag_bin_val", 32'({mag_bin_o, mag_o}),
                        32'(mag_q.pop_front()));
            end
            if (frame_done_o) n_done++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base_in, base_mag, base_done;

    initial begin
        reset = 1'b1;
        start_i = 1'b0;
        adc_data_i = '0;
        adc_valid_i = 1'b0;
        fft_done_i = 1'b0;
        fft_magnitude_i = '0;
        fft_magnitude_ready_i = 1'b0;
        repeat (2) tick();
        chk("rst_fft_reset", 32'(fft_reset_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_in_valid", 32'(fft_in_valid_o), 32'd0);
        chk("rst_mag_valid", 32'(mag_valid_o), 32'd0);
        chk("rst_index", 32'(fft_index_o), 32'd0);
        chk("rst_peak", 32'({peak_bin_o, peak_mag_o}), 32'd0);
        chk("rst_done_drop", 32'({frame_done_o, sample_drop_o}), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_fft_reset", 32'(fft_reset_o), 32'd1);

        // Frame 1: flush sequence, slow sample stream
        start_i = 1'b1;
        tick();
        chk("flush1_busy", 32'(busy_o), 32'd1);
        chk("flush1_fft_reset", 32'(fft_reset_o), 32'd1);
        repeat (3) begin
            tick();
            chk("flush_fft_reset", 32'(fft_reset_o), 32'd1);
        end
        tick();
        chk("load_fft_reset", 32'(fft_reset_o), 32'd0);
        base_in = n_in;
        for (int k = 0; k < 1024; k++) begin
            adc_data_i  = 12'hABC;
            adc_valid_i = 1'b1;
            in_q.push_back(16'hABC0);
            tick();
            chk("in_valid_latency", 32'(fft_in_valid_o), 32'd1);
            adc_valid_i = 1'b0;
            if (k != 1023) repeat (20) tick();
        end
        adc_valid_i = 1'b1;
        tick();
        chk("compute_drop", 32'(sample_drop_o), 32'd1);
        chk("compute_no_in_valid", 32'(fft_in_valid_o), 32'd0);
        adc_valid_i = 1'b0;
        tick();
        chk("drop_one_cycle", 32'(sample_drop_o), 32'd0);
        chk("in_pulse_count", 32'(n_in - base_in), 32'd1024);
        base_mag  = n_mag;
        base_done = n_done;
        fft_done_i = 1'b1;
        tick();
        fft_done_i = 1'b0;
        read_frame(1);
        chk("f1_frame_done", 32'(frame_done_o), 32'd1);
        chk("f1_peak_bin", 32'(peak_bin_o), 32'd37);
        chk("f1_peak_mag", 32'(peak_mag_o), 32'hFFFF);
        chk("f1_index_wrap", 32'(fft_index_o), 32'd0);
        tick();
        chk("f1_done_pulse", 32'(frame_done_o), 32'd0);
        chk("f2_flush_busy", 32'(busy_o), 32'd1);
        chk("f2_flush_reset", 32'(fft_reset_o), 32'd1);
        chk("f1_done_count", 32'(n_done - base_done), 32'd1);
        chk("f1_mag_count", 32'(n_mag - base_mag), 32'd1024);

        // Frame 2: back-to-back samples, DC and tie handling
        repeat (4) tick();
        chk("f2_load_reset", 32'(fft_reset_o), 32'd0);
        for (int k = 0; k < 1024; k++) begin
            adc_data_i  = 12'(k * 7 + 3);
            adc_valid_i = 1'b1;
            in_q.push_back({adc_data_i, 4'h0});
            tick();
        end
        adc_valid_i = 1'b0;
        fft_magnitude_i = 16'd1234;
        fft_magnitude_ready_i = 1'b1;
        tick();
        chk("compute_in_idle", 32'(fft_in_valid_o), 32'd0);
        tick();
        chk("ready_ignored", 32'(mag_valid_o), 32'd0);
        fft_magnitude_ready_i = 1'b0;
        base_done = n_done;
        fft_done_i = 1'b1;
        tick();
        fft_done_i = 1'b0;
        read_frame(2);
        chk("f2_frame_done", 32'(frame_done_o), 32'd1);
        chk("f2_peak_bin", 32'(peak_bin_o), 32'd5);
        chk("f2_peak_mag", 32'(peak_mag_o), 32'd100);
        tick();

        // Frame 3: abort mid-load
        repeat (4) tick();
        chk("f3_load_reset", 32'(fft_reset_o), 32'd0);
        for (int k = 0; k < 500; k++) begin
            adc_data_i  = 12'h5A5;
            adc_valid_i = 1'b1;
            in_q.push_back(16'h5A50);
            tick();
        end
        adc_valid_i = 1'b0;
        start_i = 1'b0;
        tick();
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_fft_reset", 32'(fft_reset_o), 32'd1);
        tick();
        chk("abort_no_done", 32'(n_done - base_done), 32'd1);
        chk("abort_peak_bin", 32'(peak_bin_o), 32'd5);
        chk("abort_peak_mag", 32'(peak_mag_o), 32'd100);
        adc_valid_i = 1'b1;
        tick();
        chk("idle_drop", 32'(sample_drop_o), 32'd1);
        chk("idle_no_in_valid", 32'(fft_in_valid_o), 32'd0);
        adc_valid_i = 1'b0;
        tick();
        chk("in_q_drained", 32'(in_q.size()), 32'd0);
        chk("mag_q_drained", 32'(mag_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
